// File: rtl/noc_local_endpoint.sv
// Local endpoint of a credit-based mesh NoC node.
// TX side: turns host send requests into single flits toward the router's local
// input, gated by a credit counter that mirrors the router's input buffer depth.
// RX side: buffers flits from the router's local output in a small FIFO and
// returns one credit to the router for every flit the host consumes.
module noc_local_endpoint #(
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0,
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    // router side
    output logic [15:0] net_data_o,
    output logic        net_enable_o,
    input  logic        net_credit_i,
    input  logic [15:0] net_data_i,
    input  logic        net_enable_i,
    output logic        net_credit_o,
    // host TX side
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_dest_i,
    input  logic [7:0]  tx_payload_i,
    output logic        tx_ready_o,
    // host RX side
    output logic        rx_valid_o,
    output logic [15:0] rx_data_o,
    input  logic        rx_pop_i,
    // status
    output logic        rx_overflow_o,
    output logic        credit_err_o,
    output logic [15:0] tx_count_o,
    output logic [15:0] rx_count_o
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [3:0] CRED_INIT = 4'(CREDITS);

    // Parameter sanity checks, evaluated at elaboration only.
    if (XCOORD < 0 || XCOORD > 15) begin : g_bad_xcoord
        $error("noc_local_endpoint: XCOORD must fit in 4 bits");
    end
    if (YCOORD < 0 || YCOORD > 15) begin : g_bad_ycoord
        $error("noc_local_endpoint: YCOORD must fit in 4 bits");
    end
    if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
        $error("noc_local_endpoint: CREDITS must be in 1..15");
    end
    if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_local_endpoint: RX_DEPTH must be a power of two in 2..16");
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [3:0]  r_credit;
    logic        r_net_enable;
    logic [15:0] r_net_data;
    logic        r_credit_err;
    logic [15:0] r_tx_count;
    logic        w_send;

    // Readiness depends only on the registered counter, so a returning credit
    // is visible to the host one cycle later (no combinational bypass).
    assign tx_ready_o = (r_credit != 4'd0);
    assign w_send     = tx_valid_i & tx_ready_o;

    // Credit accounting, flit launch register and send counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit     <= CRED_INIT;
            r_net_enable <= 1'b0;
            r_net_data   <= 16'h0000;
            r_credit_err <= 1'b0;
            r_tx_count   <= 16'h0000;
        end else begin
            r_net_enable <= w_send;
            if (w_send) begin
                r_net_data <= {tx_payload_i, tx_dest_i};
                r_tx_count <= r_tx_count + 16'd1;
            end
            if (w_send && !net_credit_i) begin
                r_credit <= r_credit - 4'd1;
            end else if (!w_send && net_credit_i) begin
                // A credit beyond the initial allotment means the router and
                // endpoint disagree; hold the counter and flag it.
                if (r_credit == CRED_INIT) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credit <= r_credit + 4'd1;
                end
            end
        end
    end

    assign net_enable_o = r_net_enable;
    assign net_data_o   = r_net_data;
    assign credit_err_o = r_credit_err;
    assign tx_count_o   = r_tx_count;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [15:0]   r_mem [RX_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_net_credit;
    logic          r_rx_overflow;
    logic [15:0]   r_rx_count;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_write;

    // Extra pointer bit separates full (MSBs differ) from empty (all equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = rx_pop_i & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_write = net_enable_i & (~w_full | w_pop);

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= net_data_i;
        end
    end

    // FIFO pointers, credit return pulse, overflow flag and receive counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_net_credit  <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_rx_count    <= 16'h0000;
        end else begin
            r_net_credit <= w_pop;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_write) begin
                r_wr_ptr   <= r_wr_ptr + PW'(1);
                r_rx_count <= r_rx_count + 16'd1;
            end
            if (net_enable_i && w_full && !w_pop) begin
                r_rx_overflow <= 1'b1;
            end
        end
    end

    assign rx_valid_o    = ~w_empty;
    assign rx_data_o     = r_mem[r_rd_ptr[AW-1:0]];
    assign net_credit_o  = r_net_credit;
    assign rx_overflow_o = r_rx_overflow;
    assign rx_count_o    = r_rx_count;

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Bench for noc_local_endpoint: directed scenarios followed by a random phase,
// all compared against a queue-based behavioural model of the endpoint.
module tb_noc_local_endpoint;

    localparam int CREDITS  = 4;
    localparam int RX_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] net_data_o;
    logic        net_enable_o;
    logic        net_credit_i;
    logic [15:0] net_data_i;
    logic        net_enable_i;
    logic        net_credit_o;
    logic        tx_valid_i;
    logic [7:0]  tx_dest_i;
    logic [7:0]  tx_payload_i;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [15:0] rx_data_o;
    logic        rx_pop_i;
    logic        rx_overflow_o;
    logic        credit_err_o;
    logic [15:0] tx_count_o;
    logic [15:0] rx_count_o;

    noc_local_endpoint #(
        .XCOORD   (1),
        .YCOORD   (2),
        .CREDITS  (CREDITS),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .net_data_o    (net_data_o),
        .net_enable_o  (net_enable_o),
        .net_credit_i  (net_credit_i),
        .net_data_i    (net_data_i),
        .net_enable_i  (net_enable_i),
        .net_credit_o  (net_credit_o),
        .tx_valid_i    (tx_valid_i),
        .tx_dest_i     (tx_dest_i),
        .tx_payload_i  (tx_payload_i),
        .tx_ready_o    (tx_ready_o),
        .rx_valid_o    (rx_valid_o),
        .rx_data_o     (rx_data_o),
        .rx_pop_i      (rx_pop_i),
        .rx_overflow_o (rx_overflow_o),
        .credit_err_o  (credit_err_o),
        .tx_count_o    (tx_count_o),
        .rx_count_o    (rx_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_credit;
    bit          m_net_en;
    logic [15:0] m_net_data;
    bit          m_net_credit;
    logic [15:0] m_q[$];
    bit          m_ovf;
    bit          m_cerr;
    logic [15:0] m_txc;
    logic [15:0] m_rxc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit     = CREDITS;
        m_net_en     = 0;
        m_net_data   = 16'h0000;
        m_net_credit = 0;
        m_q.delete();
        m_ovf        = 0;
        m_cerr       = 0;
        m_txc        = 16'h0000;
        m_rxc        = 16'h0000;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit send, pop, full;
        if (rst) begin
            model_reset();
            return;
        end
        send = tx_valid_i && (m_credit > 0);
        pop  = rx_pop_i && (m_q.size() > 0);
        full = (m_q.size() == RX_DEPTH);
        if (send && !net_credit_i)      m_credit--;
        else if (!send && net_credit_i) begin
            if (m_credit == CREDITS) m_cerr = 1;
            else                     m_credit++;
        end
        m_net_en = send;
        if (send) begin
            m_net_data = {tx_payload_i, tx_dest_i};
            m_txc++;
        end
        m_net_credit = pop;
        if (pop) void'(m_q.pop_front());
        if (net_enable_i) begin
            if (!full || pop) begin
                m_q.push_back(net_data_i);
                m_rxc++;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("tx_ready",    16'(tx_ready_o),    16'(m_credit > 0));
        chk("net_enable",  16'(net_enable_o),  16'(m_net_en));
        chk("net_data",    net_data_o,         m_net_data);
        chk("net_credit",  16'(net_credit_o),  16'(m_net_credit));
        chk("rx_valid",    16'(rx_valid_o),    16'(m_q.size() > 0));
        if (m_q.size() > 0) chk("rx_data", rx_data_o, m_q[0]);
        chk("rx_overflow", 16'(rx_overflow_o), 16'(m_ovf));
        chk("credit_err",  16'(credit_err_o),  16'(m_cerr));
        chk("tx_count",    tx_count_o,         m_txc);
        chk("rx_count",    rx_count_o,         m_rxc);
    endtask

    // Compare on the falling edge, then let one rising edge pass.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        tx_valid_i   = 0;
        tx_dest_i    = 8'h00;
        tx_payload_i = 8'h00;
        net_credit_i = 0;
        net_data_i   = 16'h0000;
        net_enable_i = 0;
        rx_pop_i     = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        int pulses;
        int sends;
        logic [15:0] last;
        logic [15:0] fill [4];

        // Power-on reset and reset values
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 0;
        $display("reset: initial reset state checked");

        // Burst of 6 requests with only 4 credits
        tx_dest_i = 8'h21; tx_payload_i = 8'hA5; tx_valid_i = 1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (net_enable_o && net_data_o == 16'hA521) pulses++;
        end
        tx_valid_i = 0;
        chk("burst_pulses", 16'(pulses), 16'd4);
        chk("burst_ready0", 16'(tx_ready_o), 16'd0);
        chk("burst_txcnt",  tx_count_o, 16'd4);
        $display("tx burst: pulses=%0d tx_count=%0d", pulses, tx_count_o);

        // Credit at zero: ready returns next cycle, one more send
        net_credit_i = 1;
        cycle();
        net_credit_i = 0;
        chk("credit_ready", 16'(tx_ready_o), 16'd1);
        tx_valid_i = 1;
        cycle();
        tx_valid_i = 0;
        chk("resend_en",    16'(net_enable_o), 16'd1);
        chk("resend_ready", 16'(tx_ready_o), 16'd0);
        $display("credit return: one extra send, counter back to zero");

        // Counter=2, simultaneous send and credit
        net_credit_i = 1;
        cycle(); cycle();
        net_credit_i = 0;
        tx_valid_i = 1; net_credit_i = 1;
        cycle();
        tx_valid_i = 0; net_credit_i = 0;
        chk("simul_en", 16'(net_enable_o), 16'd1);
        tx_valid_i = 1; sends = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (net_enable_o) sends++;
        end
        tx_valid_i = 0;
        chk("simul_sends", 16'(sends), 16'd2);
        $display("simultaneous send+credit: remaining sends=%0d", sends);

        // Credit at full count: error flag, counter unchanged
        net_credit_i = 1;
        for (int i = 0; i < 4; i++) cycle();
        chk("cerr_before", 16'(credit_err_o), 16'd0);
        cycle();
        net_credit_i = 0;
        chk("cerr_set", 16'(credit_err_o), 16'd1);
        tx_valid_i = 1; sends = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (net_enable_o) sends++;
        end
        tx_valid_i = 0;
        chk("cerr_sends", 16'(sends), 16'd4);
        $display("extra credit: credit_err=%0d sends=%0d", credit_err_o, sends);

        // Asynchronous reset in the middle of a burst
        net_credit_i = 1;
        cycle(); cycle();
        net_credit_i = 0;
        tx_valid_i = 1; tx_dest_i = 8'h33; tx_payload_i = 8'h5C;
        cycle();
        chk("pre_rst_en", 16'(net_enable_o), 16'd1);
        #2;
        rst = 1;
        #1;
        chk("async_en",    16'(net_enable_o), 16'd0);
        chk("async_data",  net_data_o, 16'h0000);
        chk("async_ready", 16'(tx_ready_o), 16'd1);
        chk("async_cerr",  16'(credit_err_o), 16'd0);
        chk("async_txcnt", tx_count_o, 16'd0);
        chk("async_rxv",   16'(rx_valid_o), 16'd0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 0;
        cycle();
        chk("post_rst_en",  16'(net_enable_o), 16'd0);
        chk("post_rst_crd", 16'(net_credit_o), 16'd0);
        $display("async reset: outputs at reset values before next edge");

        // RX overflow: 5 pushes, no pops
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            net_enable_i = 1;
            net_data_i   = 16'($urandom);
            cycle();
        end
        net_enable_i = 0;
        chk("ovf_set",   16'(rx_overflow_o), 16'd1);
        chk("ovf_rxcnt", rx_count_o, 16'd4);
        rx_pop_i = 1;
        for (int i = 0; i < 4; i++) cycle();
        rx_pop_i = 0;
        chk("ovf_drained", 16'(rx_valid_o), 16'd0);
        rx_pop_i = 1;
        cycle();
        rx_pop_i = 0;
        chk("empty_pop_crd", 16'(net_credit_o), 16'd0);
        cycle();
        $display("rx overflow: rx_count=%0d overflow=%0d", rx_count_o, rx_overflow_o);

        // Full FIFO with simultaneous push and pop
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            fill[i] = 16'($urandom);
            net_enable_i = 1;
            net_data_i   = fill[i];
            cycle();
        end
        net_enable_i = 1; net_data_i = 16'h1234; rx_pop_i = 1;
        cycle();
        net_enable_i = 0; rx_pop_i = 0;
        chk("fp_credit", 16'(net_credit_o), 16'd1);
        chk("fp_ovf",    16'(rx_overflow_o), 16'd0);
        chk("fp_head",   rx_data_o, fill[1]);
        cycle();
        chk("fp_credit_once", 16'(net_credit_o), 16'd0);
        last = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            last = rx_data_o;
            rx_pop_i = 1;
            cycle();
        end
        rx_pop_i = 0;
        chk("fp_tail", last, 16'h1234);
        $display("full push+pop: tail=%h overflow=%0d", last, rx_overflow_o);

        // Random traffic against the model
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            tx_valid_i   = 1'($urandom_range(0, 1));
            tx_dest_i    = 8'($urandom);
            tx_payload_i = 8'($urandom);
            net_credit_i = ($urandom_range(0, 2) == 0);
            net_enable_i = ($urandom_range(0, 2) != 0);
            net_data_i   = 16'($urandom);
            rx_pop_i     = 1'($urandom_range(0, 1));
            cycle();
        end
        clear_inputs();
        cycle();
        $display("random: 400 cycles, tx_count=%0d rx_count=%0d", tx_count_o, rx_count_o);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_local_endpoint.md
NOC_LOCAL_ENDPOINT -- requirements
Module: noc_local_endpoint

Interface
REQ-001 Parameter XCOORD, default 0, this node's X coordinate (4 bits used).
REQ-002 Parameter YCOORD, default 0, this node's Y coordinate (4 bits used).
REQ-003 Parameter CREDITS, default 4, initial TX credits; equals the router local-input buffer depth; range 1-15.
REQ-004 Parameter RX_DEPTH, default 4, RX FIFO entries; power of two, 2-16.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 net_data_o  out  16  flit to the router local input.
REQ-008 net_enable_o  out  1  flit valid on net_data_o, one cycle per flit.
REQ-009 net_credit_i  in  1  one-cycle pulse from the router; returns one TX credit.
REQ-010 net_data_i  in  16  flit from the router local output.
REQ-011 net_enable_i  in  1  net_data_i valid this cycle.
REQ-012 net_credit_o  out  1  one-cycle pulse to the router; frees one RX slot.
REQ-013 tx_valid_i  in  1  host requests a send.
REQ-014 tx_dest_i  in  8  destination: [7:4] X, [3:0] Y.
REQ-015 tx_payload_i  in  8  payload byte.
REQ-016 tx_ready_o  out  1  send accepted this cycle when high with tx_valid_i.
REQ-017 rx_valid_o  out  1  RX FIFO non-empty.
REQ-018 rx_data_o  out  16  head flit of RX FIFO.
REQ-019 rx_pop_i  in  1  host consumes the head flit.
REQ-020 rx_overflow_o  out  1  sticky: flit arrived with RX FIFO full.
REQ-021 credit_err_o  out  1  sticky: credit returned with counter already at CREDITS.
REQ-022 tx_count_o, rx_count_o  out  16 each  flits sent and received, wrapping.

Function
REQ-023 Flit format SHALL be {payload[7:0], dest[7:0]}; the router routes on bits [7:0].
REQ-024 TX credit counter (4 bits) SHALL reset to CREDITS.
REQ-025 tx_ready_o SHALL equal (credit counter != 0), combinationally from registered state only.
REQ-026 A send SHALL occur when tx_valid_i & tx_ready_o; on the next cycle net_enable_o=1 and net_data_o={tx_payload_i, tx_dest_i} as sampled.
REQ-027 net_enable_o SHALL be 0 in every cycle without a send on the previous edge; net_data_o holds its last value.
REQ-028 Send only: counter -1; credit only: counter +1; both in one cycle: counter unchanged.
REQ-029 A credit at counter==CREDITS without a simultaneous send SHALL leave the counter unchanged and set credit_err_o.
REQ-030 When the counter is 0 and net_credit_i arrives, tx_ready_o SHALL rise the following cycle; no same-cycle bypass.
REQ-031 The RX FIFO SHALL write net_data_i when net_enable_i=1, with no back-pressure to the router.
REQ-032 rx_valid_o/rx_data_o SHALL reflect the FIFO head; a write into an empty FIFO appears the next cycle.
REQ-033 A pop SHALL occur when rx_pop_i & rx_valid_o; rx_pop_i with an empty FIFO is ignored and returns no credit.
REQ-034 net_credit_o SHALL pulse high exactly one cycle, registered, in the cycle after each pop.
REQ-035 Write when full with a simultaneous pop SHALL be accepted, with no overflow.
REQ-036 Write when full without a pop SHALL drop the flit, set rx_overflow_o, and leave the FIFO unchanged.
REQ-037 Read and write pointers SHALL wrap modulo RX_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-038 tx_count_o SHALL increment per send, and rx_count_o per accepted RX write, wrapping from 0xFFFF to 0.

Reset
REQ-039 On rst: credit counter=CREDITS; FIFO empty; net_enable_o=0; net_credit_o=0; net_data_o=0; rx_overflow_o=0; credit_err_o=0; counts=0.
REQ-040 Reset asserted mid-operation SHALL discard in-flight sends and pending credits; no net_enable_o or net_credit_o pulse in the cycle after deassertion.

Verification
REQ-041 CREDITS=4, tx_valid_i held 6 cycles, dest 0x21, payload 0xA5, no credits -> exactly 4 net_enable_o pulses of 0xA521; tx_ready_o=0 after the 4th; tx_count_o=4.
REQ-042 Counter=0, pulse net_credit_i -> tx_ready_o=1 next cycle; one further send; counter returns to 0.
REQ-043 Counter=2, simultaneous send and net_credit_i -> counter stays 2; net_enable_o=1 next cycle.
REQ-044 RX_DEPTH=4, push 5 flits with no pops -> rx_overflow_o=1, 4 flits retained, 5th dropped; rx_count_o=4.
REQ-045 Full FIFO, simultaneous push 0x1234 and pop -> no overflow; net_credit_o pulses once next cycle; 0x1234 becomes the tail.
REQ-046 Credit at counter=CREDITS -> credit_err_o=1, counter unchanged; rst asserted asynchronously mid-burst -> all outputs at reset values before the next edge.
